// File: rtl/cr_tlvp_ob_arb_pkg.sv
// Shared constants for the TLVP outbound arbiter: bus width, FSM encoding and
// index-width helper.
package cr_tlvp_ob_arb_pkg;

  localparam int unsigned TLVP_DW = 128;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  // Index width that stays legal for a single-entry vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/cr_tlvp_ob_arb_if.sv
// Requester-side and parser-side signals of the TLVP outbound arbiter.
// slave is the arbiter's view, master the surrounding logic's view.
interface cr_tlvp_ob_arb_if
  import cr_tlvp_ob_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DW    = TLVP_DW
) ();

  localparam int unsigned IW = idx_w(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_rdy;
  logic                usr_ob_wr;
  logic [DW-1:0]       usr_ob_tlv;
  logic                usr_ob_afull;
  logic [IW-1:0]       grant_id;
  logic                busy;
  logic                err_overlen;

  modport slave (
    input  req_valid, req_data, req_last, usr_ob_afull,
    output req_rdy, usr_ob_wr, usr_ob_tlv, grant_id, busy, err_overlen
  );

  modport master (
    output req_valid, req_data, req_last, usr_ob_afull,
    input  req_rdy, usr_ob_wr, usr_ob_tlv, grant_id, busy, err_overlen
  );

endinterface

// File: rtl/cr_rr_pick.sv
// Combinational round-robin first-one search: lowest set bit of req at or
// above ptr, wrapping past N_REQ-1 back to 0.
module cr_rr_pick
  import cr_tlvp_ob_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [idx_w(N_REQ)-1:0]  ptr,
  output logic [idx_w(N_REQ)-1:0]  idx,
  output logic                     found
);

  localparam int unsigned IW = idx_w(N_REQ);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/cr_tlvp_ob_arb.sv
// Frame-atomic round-robin arbiter merging N_REQ TLV producers onto the parser
// user outbound write port, with a forced release for over-long units.
module cr_tlvp_ob_arb
  import cr_tlvp_ob_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = TLVP_DW,
  parameter int unsigned MAX_BEATS = 64
) (
  input logic               clk,
  input logic               rst,
  cr_tlvp_ob_arb_if.slave   bus
);

  localparam int unsigned IW = idx_w(N_REQ);
  localparam int unsigned CW = $clog2(MAX_BEATS + 1);

  logic [0:0]       state_q, state_nxt;
  logic [IW-1:0]    grant_q, grant_nxt, rr_q, rr_nxt, pick_idx, rr_after;
  logic             pick_found;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             wr_q, wr_nxt, err_q, err_nxt;
  logic [DW-1:0]    tlv_q, tlv_nxt, sel_data;
  logic             sel_valid, sel_last, beat;
  logic [N_REQ-1:0] rdy_c;

  cr_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Route the granted requester's word, valid and last.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == grant_q) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign beat     = (state_q == ST_LOCK) && sel_valid && !bus.usr_ob_afull;
  assign rr_after = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rdy_c[i] = beat && (IW'(i) == grant_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next state, grant/pointer/counter updates and output-stage loads.
  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    rr_nxt    = rr_q;
    cnt_nxt   = cnt_q;
    wr_nxt    = 1'b0;
    tlv_nxt   = tlv_q;
    err_nxt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
          state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (beat) begin
          wr_nxt  = 1'b1;
          tlv_nxt = sel_data;
          if (sel_last || (cnt_q == CW'(MAX_BEATS - 1))) begin
            // last wins over the length limit when both land on one beat
            err_nxt   = !sel_last;
            state_nxt = ST_IDLE;
            rr_nxt    = rr_after;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      tlv_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_nxt;
      rr_q    <= rr_nxt;
      cnt_q   <= cnt_nxt;
      wr_q    <= wr_nxt;
      tlv_q   <= tlv_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.req_rdy     = rdy_c;
  assign bus.usr_ob_wr   = wr_q;
  assign bus.usr_ob_tlv  = tlv_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q == ST_LOCK);
  assign bus.err_overlen = err_q;

endmodule

// File: tb/tb_cr_tlvp_ob_arb.sv
// Scoreboard bench for cr_tlvp_ob_arb: per-requester word queues feed the
// DUT, expected output words are queued in predicted arbitration order.
module tb_cr_tlvp_ob_arb;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  logic clk;
  logic rst;

  word_t         src_q [NR][$];
  logic [DW-1:0] exp_q [$];
  logic [NR-1:0] hold_mask;
  int            n_vec;
  int            n_err;
  int            err_pulses;

  cr_tlvp_ob_arb_if #(.N_REQ(NR), .DW(DW)) ifc ();

  cr_tlvp_ob_arb #(.N_REQ(NR), .DW(DW), .MAX_BEATS(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] tag(input int s, input int u, input int k);
    return {4'(s), 12'(u), 16'(k)};
  endfunction

  task automatic src_unit(input int s, input int u, input int n, input bit last);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.d = tag(s, u, k);
      w.l = last && (k == n - 1);
      src_q[s].push_back(w);
    end
  endtask

  task automatic exp_unit(input int s, input int u, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(tag(s, u, k));
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  function automatic bit src_empty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    flush();
    hold_mask = '0;
    ifc.usr_ob_afull = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(src_empty() && exp_q.size() == 0 && ifc.busy === 1'b0) && c < budget);
    n_vec++;
    if (!(src_empty() && exp_q.size() == 0 && ifc.busy === 1'b0)) begin
      n_err++;
      $display("FAIL %s drain: busy=%b pending_exp=%0d, required idle and drained within %0d cycles",
               name, ifc.busy, exp_q.size(), budget);
    end
  endtask

  // Requester driver: sample handshakes mid-cycle, advance queues after the edge.
  initial begin
    logic [NR-1:0] acc;
    ifc.req_valid = '0;
    ifc.req_data  = '0;
    ifc.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = ifc.req_valid & ifc.req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        if (src_q[i].size() != 0 && !hold_mask[i]) begin
          ifc.req_valid[i]          = 1'b1;
          ifc.req_data[i*DW +: DW]  = src_q[i][0].d;
          ifc.req_last[i]           = src_q[i][0].l;
        end else begin
          ifc.req_valid[i] = 1'b0;
          ifc.req_last[i]  = 1'b0;
        end
      end
    end
  end

  // Output monitor: every write is checked against the head of the scoreboard.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (ifc.usr_ob_wr === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard: unexpected write tlv=%h, none expected", ifc.usr_ob_tlv);
        end else begin
          e = exp_q.pop_front();
          if (ifc.usr_ob_tlv !== e) begin
            n_err++;
            $display("FAIL scoreboard: tlv=%h, required %h", ifc.usr_ob_tlv, e);
          end
        end
      end
      if (ifc.err_overlen === 1'b1) err_pulses++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: %b, required 0", ifc.busy); end
    n_vec++; if (ifc.usr_ob_wr !== 1'b0) begin n_err++; $display("FAIL reset wr: %b, required 0", ifc.usr_ob_wr); end
    n_vec++; if (ifc.usr_ob_tlv !== '0) begin n_err++; $display("FAIL reset tlv: %h, required 0", ifc.usr_ob_tlv); end
    n_vec++; if (ifc.grant_id !== 2'd0) begin n_err++; $display("FAIL reset grant: %0d, required 0", ifc.grant_id); end
    n_vec++; if (ifc.err_overlen !== 1'b0) begin n_err++; $display("FAIL reset err: %b, required 0", ifc.err_overlen); end
    n_vec++; if (ifc.req_rdy !== 4'b0) begin n_err++; $display("FAIL reset rdy: %b, required 0000", ifc.req_rdy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int c, nwr, first, last;
    do_reset();
    src_unit(2, 0, 3, 1'b1);
    exp_unit(2, 0, 3);
    c = 0;
    do begin @(negedge clk); c++; end while (ifc.req_valid[2] !== 1'b1 && c < 20);
    n_vec++;
    if (ifc.req_valid[2] !== 1'b1) begin n_err++; $display("FAIL single valid: never presented, required within 20 cycles"); end
    @(negedge clk);
    n_vec++;
    if (ifc.busy !== 1'b1 || ifc.grant_id !== 2'd2) begin
      n_err++; $display("FAIL single grant: busy=%b grant=%0d, required busy=1 grant=2", ifc.busy, ifc.grant_id);
    end
    nwr = 0; first = -1; last = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifc.usr_ob_wr === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        nwr++;
      end
    end
    n_vec++;
    if (nwr != 3 || first != 0 || last != 2) begin
      n_err++; $display("FAIL single wr_run: count=%0d first=%0d last=%0d, required 3/0/2", nwr, first, last);
    end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL single release: busy=%b, required 0", ifc.busy); end
    // rr_ptr should now be 3, so 3 beats 0
    src_unit(0, 1, 1, 1'b1);
    src_unit(3, 1, 1, 1'b1);
    exp_unit(3, 1, 1);
    exp_unit(0, 1, 1);
    wait_idle(40, "single_rr");
  endtask

  task automatic test_rr_all();
    int c, nwr, prev;
    do_reset();
    for (int u = 0; u < 2; u++)
      for (int s = 0; s < NR; s++) begin
        src_unit(s, u, 1, 1'b1);
        exp_unit(s, u, 1);
      end
    c = 0; nwr = 0; prev = 0;
    while (nwr < 8 && c < 60) begin
      @(negedge clk);
      c++;
      if (ifc.usr_ob_wr === 1'b1) begin
        if (nwr > 0) begin
          n_vec++;
          if (c - prev != 2) begin n_err++; $display("FAIL rr_all gap: %0d cycles, required 2", c - prev); end
        end
        prev = c;
        nwr++;
      end
    end
    n_vec++; if (nwr != 8) begin n_err++; $display("FAIL rr_all count: %0d writes, required 8", nwr); end
    wait_idle(40, "rr_all");
  endtask

  task automatic test_no_interleave();
    int c, viol;
    do_reset();
    src_unit(1, 0, 3, 1'b1);
    exp_unit(1, 0, 3);
    c = 0;
    do begin @(negedge clk); c++; end while (ifc.usr_ob_wr !== 1'b1 && c < 20);
    n_vec++; if (ifc.usr_ob_wr !== 1'b1) begin n_err++; $display("FAIL nointlv start: no write, required one within 20 cycles"); end
    // bubble on req 1 while req 0 competes
    hold_mask[1] = 1'b1;
    src_unit(0, 0, 1, 1'b1);
    exp_unit(0, 0, 1);
    viol = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifc.req_rdy[0] !== 1'b0 || ifc.grant_id !== 2'd1 || ifc.busy !== 1'b1) viol++;
    end
    n_vec++; if (viol != 0) begin n_err++; $display("FAIL nointlv hold: %0d bad cycles, required 0", viol); end
    hold_mask[1] = 1'b0;
    wait_idle(40, "nointlv");
  endtask

  task automatic test_afull();
    int c, base;
    do_reset();
    base = err_pulses;
    src_unit(2, 0, 4, 1'b1);
    exp_unit(2, 0, 4);
    c = 0;
    do begin @(negedge clk); c++; end while (ifc.usr_ob_wr !== 1'b1 && c < 20);
    n_vec++; if (ifc.usr_ob_wr !== 1'b1) begin n_err++; $display("FAIL afull start: no write, required one within 20 cycles"); end
    @(posedge clk); #1;
    ifc.usr_ob_afull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (ifc.req_rdy !== 4'b0) begin n_err++; $display("FAIL afull rdy[%0d]: %b, required 0000", i, ifc.req_rdy); end
      if (i > 0) begin
        n_vec++; if (ifc.usr_ob_wr !== 1'b0) begin n_err++; $display("FAIL afull wr[%0d]: %b, required 0", i, ifc.usr_ob_wr); end
      end
    end
    @(posedge clk); #1;
    ifc.usr_ob_afull = 1'b0;
    @(negedge clk);
    n_vec++; if (ifc.usr_ob_wr !== 1'b0) begin n_err++; $display("FAIL afull wr_tail: %b, required 0", ifc.usr_ob_wr); end
    wait_idle(40, "afull");
    n_vec++; if (err_pulses != base) begin n_err++; $display("FAIL afull overlen: %0d pulses, required 0", err_pulses - base); end
  endtask

  task automatic test_overlen();
    int c, nwr, base;
    do_reset();
    base = err_pulses;
    src_unit(3, 0, 4, 1'b0);
    src_unit(3, 1, 2, 1'b1);
    exp_unit(3, 0, 4);
    exp_unit(3, 1, 2);
    c = 0; nwr = 0;
    while (nwr < 4 && c < 30) begin
      @(negedge clk);
      c++;
      if (ifc.usr_ob_wr === 1'b1) begin
        nwr++;
        n_vec++;
        if (ifc.err_overlen !== 1'(nwr == 4)) begin
          n_err++; $display("FAIL overlen pulse@beat%0d: %b, required %b", nwr, ifc.err_overlen, nwr == 4);
        end
        if (nwr == 4) begin
          n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL overlen release: busy=%b, required 0", ifc.busy); end
        end
      end
    end
    n_vec++; if (nwr != 4) begin n_err++; $display("FAIL overlen count: %0d writes, required 4", nwr); end
    wait_idle(40, "overlen");
    n_vec++; if (err_pulses - base != 1) begin n_err++; $display("FAIL overlen pulses: %0d, required 1", err_pulses - base); end
  endtask

  task automatic test_reset_mid();
    int c, nb;
    do_reset();
    src_unit(1, 0, 1, 1'b1);
    exp_unit(1, 0, 1);
    wait_idle(20, "rstmid_pre");
    src_unit(2, 1, 4, 1'b1);
    exp_unit(2, 1, 2);
    c = 0; nb = 0;
    while (nb < 2 && c < 30) begin
      @(negedge clk);
      c++;
      if (ifc.req_rdy[2] === 1'b1) nb++;
    end
    n_vec++; if (nb != 2) begin n_err++; $display("FAIL rstmid beats: %0d, required 2", nb); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rstmid busy: %b, required 0", ifc.busy); end
    n_vec++; if (ifc.usr_ob_wr !== 1'b0) begin n_err++; $display("FAIL rstmid wr: %b, required 0", ifc.usr_ob_wr); end
    n_vec++; if (ifc.grant_id !== 2'd0) begin n_err++; $display("FAIL rstmid grant: %0d, required 0", ifc.grant_id); end
    n_vec++; if (ifc.req_rdy !== 4'b0) begin n_err++; $display("FAIL rstmid rdy: %b, required 0000", ifc.req_rdy); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rstmid written: %0d words missing, required 0", exp_q.size()); end
    flush();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    // pointer cleared by reset: 0 must win over 3
    src_unit(0, 2, 1, 1'b1);
    src_unit(3, 2, 1, 1'b1);
    exp_unit(0, 2, 1);
    exp_unit(3, 2, 1);
    wait_idle(40, "rstmid_post");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    err_pulses = 0;
    hold_mask = '0;
    rst = 1'b1;
    ifc.usr_ob_afull = 1'b0;
    test_reset();
    test_single();
    test_rr_all();
    test_no_interleave();
    test_afull();
    test_overlen();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cr_tlvp_ob_arb.md
Name: cr_tlvp_ob_arb

Overview:
- Frame-atomic round-robin arbiter that merges N user TLV producers onto the single usr_ob_wr/usr_ob_tlv write port of the TLV parser.
- Sits between the engine-side TLV generators and the parser's user outbound FIFO.
- Once a requester is granted, it holds the grant until it signals the last word of its TLV unit. Units from different requesters are never interleaved.
- Includes an over-length guard that force-releases a requester that never terminates its unit.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 128, width of one TLV word on usr_ob_tlv.
- MAX_BEATS, 64, maximum words per locked unit before forced release.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*DW  per-requester TLV word; requester i occupies bits [i*DW +: DW].
- req_last  in  N_REQ  marks the final word of the requester's atomic TLV unit.
- req_rdy  out  N_REQ  word accepted this cycle.
- usr_ob_wr  out  1  registered write strobe to the parser user outbound FIFO.
- usr_ob_tlv  out  DW  registered TLV word.
- usr_ob_afull  in  1  parser outbound FIFO almost full.
- grant_id  out  $clog2(N_REQ)  current owner; valid while busy=1.
- busy  out  1  a unit is in progress (state LOCK).
- err_overlen  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, rr_ptr=0, beat_cnt=0, grant_id=0. Outputs busy=0, req_rdy=0, usr_ob_wr=0, usr_ob_tlv=0, err_overlen=0.
- Reset mid-unit aborts the unit. A partially written unit is not recovered; the requester must restart it.
- FSM has two states, IDLE and LOCK.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr with wrap.
  - Register the pick in grant_id and move to LOCK next cycle. Grant latency is 1 cycle.
  - No word is accepted in IDLE, so req_rdy=0.
- LOCK, accept rule:
  - req_rdy[grant_id] = req_valid[grant_id] & ~usr_ob_afull. All other req_rdy bits are 0.
  - A beat is that condition being true.
- LOCK, output stage:
  - On a beat, usr_ob_wr=1 and usr_ob_tlv=req_data[grant_id] on the following cycle.
  - Otherwise usr_ob_wr=0 and usr_ob_tlv holds its last value.
  - This 1-cycle write latency is covered by the parser FIFO's afull margin (N_UF_AFULL_VAL ≥ 2).
- LOCK, beat counting: each beat increments beat_cnt (width $clog2(MAX_BEATS+1)).
- LOCK, normal release: a beat with req_last[grant_id]=1 moves to IDLE, sets rr_ptr=(grant_id+1) mod N_REQ, and clears beat_cnt.
- LOCK, forced release:
  - Triggered by the beat that makes beat_cnt reach MAX_BEATS without req_last.
  - Move to IDLE, pulse err_overlen for 1 cycle, set rr_ptr=grant_id+1 mod N_REQ, clear beat_cnt.
  - The requester's next word is treated as the start of a new unit.
- usr_ob_afull high in LOCK stalls with no beat and no counter change. The grant is held indefinitely; no idle timeout.
- A requester dropping req_valid mid-unit keeps the grant (bubble allowed).
- Simultaneous last and MAX_BEATS on the same beat counts as a normal release; err_overlen is not pulsed.
- Fairness: after release, the releasing requester has lowest priority. With all requesters busy, units are serviced in order 0,1,2,3,0.
- Single-word units (req_last on the first beat) are supported. Minimum unit period is 2 cycles (IDLE + 1 beat).
- A requester with valid=1 and last=0 is never interrupted by higher-priority requesters.

Decomposition:
- Shared package: TLVP word width constant (reuse the existing TLV bus width define) and the FSM state enum for cr_tlvp_ob_arb.
- One natural sub-module: cr_rr_pick. It is a combinational round-robin first-one search taking N_REQ, req vector and pointer, and returning the index plus a found flag. The top holds the FSM, beat counter and output register.

Test Plan:
- N_REQ=4, only req 2 valid, 3-word unit with last on word 3, afull=0 -> grant_id=2 one cycle after valid; usr_ob_wr high for 3 consecutive cycles; rr_ptr=3; busy returns to 0.
- All 4 requesters continuously valid, single-word units -> usr_ob_tlv sources follow 0,1,2,3,0,1 with a write every 2 cycles.
- Req 1 locked mid-unit while req 0 asserts valid -> req_rdy[0]=0 until req 1's last word; no interleaving on usr_ob_tlv.
- usr_ob_afull=1 for 5 cycles mid-unit -> req_rdy=0 and usr_ob_wr=0 starting the cycle after afull rises, for 5 cycles; beat_cnt is frozen; the unit resumes with no lost or duplicated word.
- MAX_BEATS=4, req 3 sends 6 words with no last -> err_overlen pulses on the cycle after beat 4; arbiter returns to IDLE; words 5–6 form a new unit.
- rst=1 asserted during LOCK at beat 2 -> next cycle busy=0, usr_ob_wr=0, grant_id=0; arbitration restarts from req 0.
